alu_operand_stage: RTL and testbench

Decode-and-operand stage directly upstream of the 16-bit ALU. Accepts one 16-bit instruction per handshake, decodes the ALU control code, and reads two operands from an internal 8×16 register file, with a writeback bypass. It presents Aluctrl/din1/din2 plus destination to the ALU from a single output register under valid/ready flow control. The ALU result returns through the writeback port.

---
 rtl/alu_operand_stage_if.sv | 30 +++
 rtl/alu_operand_stage.sv | 98 +++++++++
 tb/tb_alu_operand_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Handshake, operand and writeback bundle between the issuer, the operand stage and the ALU.
// The slave modport is the operand stage; master is the issuer/ALU side.
interface alu_operand_stage_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        aluctrl;
    logic [DATA_W-1:0] din1;
    logic [DATA_W-1:0] din2;
    logic [AW-1:0]     rd;
    logic              illegal;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, aluctrl, din1, din2, rd, illegal
    );

    modport slave (
        input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, aluctrl, din1, din2, rd, illegal
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Decode-and-operand stage: decodes one instruction per handshake, reads an 8x16
// register file with writeback bypass, and holds ALU operands in a single output register.
module alu_operand_stage #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input logic               clk,
    input logic               rst_n,
    alu_operand_stage_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [DATA_W-1:0] regs [NREG];

    logic [3:0]        opcode;
    logic [AW-1:0]     f_rd, f_rs1, f_rs2;
    logic              f_imm;
    logic              is_nop, is_ill, accept, in_ready;
    logic [DATA_W-1:0] rs1_val, rs2_val, op2_val;

    logic              out_valid, illegal;
    logic [3:0]        aluctrl;
    logic [DATA_W-1:0] din1, din2;
    logic [AW-1:0]     rd;
    logic [AW-1:0]     h_rs1, h_rs2;
    logic              h_imm;
    logic              wb_hit;

    assign opcode = bus.instr[15:12];
    assign f_rd   = bus.instr[11:9];
    assign f_rs1  = bus.instr[8:6];
    assign f_imm  = bus.instr[5];
    assign f_rs2  = bus.instr[4:2];
    assign is_nop = (opcode == 4'b0000);
    assign is_ill = (opcode[3:1] == 3'b111);

    assign in_ready = !out_valid || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign wb_hit   = bus.wb_en && (bus.wb_addr != '0);

    // r0 is hardwired to zero; a same-cycle writeback to the source register wins over the array
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (f_rs1 != '0)
            rs1_val = (wb_hit && bus.wb_addr == f_rs1) ? bus.wb_data : regs[f_rs1];
        if (f_rs2 != '0)
            rs2_val = (wb_hit && bus.wb_addr == f_rs2) ? bus.wb_data : regs[f_rs2];
        op2_val = f_imm ? {{(DATA_W-5){1'b0}}, bus.instr[4:0]} : rs2_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '{default: '0};
        else if (wb_hit)
            regs[bus.wb_addr] <= bus.wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            aluctrl   <= '0;
            din1      <= '0;
            din2      <= '0;
            rd        <= '0;
            h_rs1     <= '0;
            h_rs2     <= '0;
            h_imm     <= 1'b0;
        end else if (accept && !is_nop) begin
            out_valid <= 1'b1;
            illegal   <= is_ill;
            aluctrl   <= is_ill ? 4'b0000 : opcode;
            din1      <= is_ill ? '0 : rs1_val;
            din2      <= is_ill ? '0 : op2_val;
            rd        <= f_rd;
            h_rs1     <= f_rs1;
            h_rs2     <= f_rs2;
            h_imm     <= f_imm;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid && !illegal && wb_hit) begin
            // Stalled: track writebacks to the held source registers; illegal entries keep zero operands
            if (bus.wb_addr == h_rs1)
                din1 <= bus.wb_data;
            if (!h_imm && bus.wb_addr == h_rs2)
                din2 <= bus.wb_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.illegal   = illegal;
    assign bus.aluctrl   = aluctrl;
    assign bus.din1      = din1;
    assign bus.din2      = din2;
    assign bus.rd        = rd;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: decoded instructions are queued on accept and
// resolved against a model register file when the stage hands them to the ALU.
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic rst_n;

    alu_operand_stage_if #(.DATA_W(16), .AW(3)) bus ();

    alu_operand_stage #(.DATA_W(16), .NREG(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       imm;
        logic [4:0] imm5;
    } item_t;

    item_t       q[$];
    logic [15:0] mregs [8];
    int          checks = 0;
    int          errors = 0;
    int          xfers  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rdv,
                                        input logic [2:0] rs1, input logic imm, input logic [4:0] low);
        return {op, rdv, rs1, imm, low};
    endfunction

    function automatic logic [15:0] rreg(input logic [2:0] a);
        return (a == 3'd0) ? 16'h0000 : mregs[a];
    endfunction

    // Monitor: a held instruction's register operands equal the register contents at the
    // start of its transfer cycle; immediates are fixed at issue; illegal ops carry zeros.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
            chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        end else begin
            logic exp_ov;
            exp_ov = (q.size() != 0);
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_ov});
            chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (!exp_ov || bus.out_ready)});
            if (exp_ov && bus.out_ready) begin
                item_t it;
                logic ill;
                it  = q.pop_front();
                ill = (it.op >= 4'd14);
                xfers++;
                chk("illegal", {31'b0, bus.illegal}, {31'b0, ill});
                chk("aluctrl", {28'b0, bus.aluctrl}, ill ? 32'd0 : {28'b0, it.op});
                chk("rd", {29'b0, bus.rd}, {29'b0, it.rd});
                chk("din1", {16'b0, bus.din1}, ill ? 32'd0 : {16'b0, rreg(it.rs1)});
                chk("din2", {16'b0, bus.din2},
                    ill ? 32'd0 : (it.imm ? {27'b0, it.imm5} : {16'b0, rreg(it.rs2)}));
            end
            if (bus.in_valid && (!exp_ov || bus.out_ready) && bus.instr[15:12] != 4'd0) begin
                item_t n;
                n.op   = bus.instr[15:12];
                n.rd   = bus.instr[11:9];
                n.rs1  = bus.instr[8:6];
                n.imm  = bus.instr[5];
                n.rs2  = bus.instr[4:2];
                n.imm5 = bus.instr[4:0];
                q.push_back(n);
            end
            if (bus.wb_en && bus.wb_addr != 3'd0) mregs[bus.wb_addr] = bus.wb_data;
        end
    end

    task automatic step(input logic iv, input logic [15:0] ins, input logic ordy,
                        input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        output logic acc);
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.out_ready = ordy;
        bus.wb_en     = we;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        acc;
        logic [15:0] cur;
        logic        have;
        int          xf0;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.instr = '0; bus.out_ready = 1'b0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        #1;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_aluctrl", {28'b0, bus.aluctrl}, 32'd0);
        chk("rst_din1", {16'b0, bus.din1}, 32'd0);
        chk("rst_din2", {16'b0, bus.din2}, 32'd0);
        chk("rst_rd_illegal", {28'b0, bus.rd, bus.illegal}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // r1=5, r2=3, add r3,r1,r2, then immediate op
        step(0, '0, 1, 1, 3'd1, 16'h0005, acc);
        step(0, '0, 1, 1, 3'd2, 16'h0003, acc);
        step(1, enc(4'h1, 3'd3, 3'd1, 1'b0, {3'd2, 2'b00}), 1, 0, 0, 0, acc);
        step(1, enc(4'hC, 3'd5, 3'd1, 1'b1, 5'h1F), 1, 0, 0, 0, acc);
        // same-cycle bypass, then r0 write ignored
        step(1, enc(4'h2, 3'd4, 3'd1, 1'b0, {3'd0, 2'b00}), 1, 1, 3'd1, 16'hBEEF, acc);
        step(0, '0, 1, 1, 3'd0, 16'h1234, acc);
        step(1, enc(4'h1, 3'd5, 3'd0, 1'b0, {3'd0, 2'b00}), 1, 0, 0, 0, acc);
        // stall with refresh of held rs2
        step(1, enc(4'h1, 3'd6, 3'd1, 1'b0, {3'd2, 2'b00}), 1, 0, 0, 0, acc);
        step(1, enc(4'h3, 3'd7, 3'd2, 1'b0, {3'd1, 2'b00}), 0, 0, 0, 0, acc);
        step(1, enc(4'h3, 3'd7, 3'd2, 1'b0, {3'd1, 2'b00}), 0, 1, 3'd2, 16'h00AA, acc);
        step(1, enc(4'h3, 3'd7, 3'd2, 1'b0, {3'd1, 2'b00}), 0, 0, 0, 0, acc);
        step(1, enc(4'h3, 3'd7, 3'd2, 1'b0, {3'd1, 2'b00}), 1, 0, 0, 0, acc);
        chk("stall_then_accept", {31'b0, acc}, 32'd1);
        step(0, '0, 1, 0, 0, 0, acc);
        // NOP produces nothing; 1111 is captured as illegal
        step(1, 16'h0123, 1, 0, 0, 0, acc);
        step(0, '0, 1, 0, 0, 0, acc);
        step(1, enc(4'hF, 3'd6, 3'd1, 1'b0, {3'd2, 2'b00}), 1, 0, 0, 0, acc);
        step(0, '0, 1, 0, 0, 0, acc);
        // four back-to-back
        xf0 = xfers;
        for (int i = 0; i < 4; i++)
            step(1, enc(4'(i + 4), 3'(i), 3'(i + 1), 1'b0, {3'(7 - i), 2'b00}), 1, 0, 0, 0, acc);
        step(0, '0, 1, 0, 0, 0, acc);
        chk("b2b_transfers", xfers - xf0, 32'd4);

        // randomized traffic, instruction held until accepted
        have = 1'b0;
        cur  = '0;
        for (int i = 0; i < 600; i++) begin
            if (!have) begin
                cur  = 16'($urandom);
                have = 1'b1;
            end
            step(($urandom_range(0, 3) != 0), cur, ($urandom_range(0, 2) != 0),
                 1'($urandom), 3'($urandom), 16'($urandom), acc);
            if (acc) have = 1'b0;
        end

        // reset mid-stall: immediate drop, regfile cleared
        step(1, enc(4'h5, 3'd1, 3'd1, 1'b0, {3'd2, 2'b00}), 0, 0, 0, 0, acc);
        step(0, '0, 0, 0, 0, 0, acc);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, enc(4'h1, 3'd7, 3'd1, 1'b0, {3'd2, 2'b00}), 1, 0, 0, 0, acc);
        step(0, '0, 1, 0, 0, 0, acc);
        step(0, '0, 1, 0, 0, 0, acc);
        chk("queue_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
